// File: rtl/card_row_renderer_pkg.sv
// card_row_renderer_pkg: shared card geometry, type range and layout defaults for the card row renderer.
package card_row_renderer_pkg;
  localparam int CARD_W = 32;
  localparam int CARD_H = 46;
  localparam int CARD_TYPE_W = 6;
  localparam int MAX_CARD_TYPE = 53;
  localparam int RGB_W = 12;
  localparam int DEF_X0 = 64;
  localparam int DEF_Y0 = 400;
  localparam int DEF_PITCH = 36;
  localparam int SLOT_W = 5;
  localparam int OFF_W = 8;
endpackage

// File: rtl/card_slot_tracker.sv
// card_slot_tracker: divider-free (slot, offset) tracking of the beam column, resynced at X0 each line.
module card_slot_tracker
  import card_row_renderer_pkg::*;
#(
  parameter int MAX_CARDS = 16,
  parameter int X0 = DEF_X0,
  parameter int PITCH = DEF_PITCH
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  output logic [SLOT_W-1:0] slot,
  output logic [OFF_W-1:0]  offset
);
  logic [SLOT_W-1:0] slot_q;
  logic [OFF_W-1:0] off_q;
  logic wrap;
  always_comb begin
    slot = (h_cnt == 10'(X0)) ? '0 : slot_q;
    offset = (h_cnt == 10'(X0)) ? '0 : off_q;
    wrap = offset == OFF_W'(PITCH - 1);
  end
  // slot sticks at MAX_CARDS (out of row) until the next resync
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      off_q <= '0;
    end else begin
      off_q <= wrap ? '0 : offset + 1'b1;
      slot_q <= (wrap && slot != SLOT_W'(MAX_CARDS)) ? slot + 1'b1 : slot;
    end
endmodule

// File: rtl/card_row_renderer.sv
// card_row_renderer: follows the beam over a row of hand cards, requests card pixels and re-aligns them into a colour plus hit flag.
module card_row_renderer
  import card_row_renderer_pkg::*;
#(
  parameter int MAX_CARDS = 16,
  parameter int X0 = DEF_X0,
  parameter int Y0 = DEF_Y0,
  parameter int PITCH = DEF_PITCH,
  parameter int RAISE = 8,
  parameter int MEM_LAT = 1,
  parameter int V_LATCH = 480,
  parameter logic [RGB_W-1:0] BG_COLOR = 12'h000
) (
  input  logic                              clk_25MHz,
  input  logic                              rst_n,
  input  logic [9:0]                        h_cnt,
  input  logic [9:0]                        v_cnt,
  input  logic                              valid,
  input  logic [CARD_TYPE_W*MAX_CARDS-1:0]  hand_cards,
  input  logic [4:0]                        hand_count,
  input  logic [4:0]                        sel_idx,
  input  logic [RGB_W-1:0]                  card_pixel,
  output logic [5:0]                        pixel_x,
  output logic [5:0]                        pixel_y,
  output logic [CARD_TYPE_W-1:0]            card_type,
  output logic                              pix_hit,
  output logic [RGB_W-1:0]                  pix_rgb,
  output logic                              pix_valid
);
  logic [CARD_TYPE_W*MAX_CARDS-1:0] sh_cards;
  logic [4:0] sh_count, sh_sel;
  logic [SLOT_W-1:0] slot;
  logic [OFF_W-1:0] offset;
  logic [CARD_TYPE_W-1:0] cur_type;
  logic [9:0] top;
  logic [5:0] py;
  logic row_hit, hit;
  logic hit_d [MEM_LAT+1];
  logic val_d [MEM_LAT+1];

  card_slot_tracker #(.MAX_CARDS(MAX_CARDS), .X0(X0), .PITCH(PITCH)) u_tracker (
    .clk_25MHz(clk_25MHz),
    .rst_n(rst_n),
    .h_cnt(h_cnt),
    .slot(slot),
    .offset(offset)
  );

  always_comb begin
    cur_type = (slot < SLOT_W'(MAX_CARDS)) ? sh_cards[CARD_TYPE_W*slot +: CARD_TYPE_W] : '0;
    top = (slot == sh_sel) ? 10'(Y0 - RAISE) : 10'(Y0);
    row_hit = v_cnt >= top && v_cnt < top + 10'(CARD_H);
    py = 6'(v_cnt - top);
    hit = valid && slot < sh_count && offset < OFF_W'(CARD_W) && row_hit &&
          cur_type <= CARD_TYPE_W'(MAX_CARD_TYPE);
  end

  // hand inputs are only sampled once per frame, outside the card rows
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) begin
      sh_cards <= '0;
      sh_count <= '0;
      sh_sel <= '0;
    end else if (v_cnt == 10'(V_LATCH) && h_cnt == 10'd0) begin
      sh_cards <= hand_cards;
      sh_count <= (hand_count > 5'(MAX_CARDS)) ? 5'(MAX_CARDS) : hand_count;
      sh_sel <= sel_idx;
    end

  // hit/valid ride alongside the memory request so the returned pixel lines up
  always_ff @(posedge clk_25MHz or negedge rst_n)
    if (!rst_n) begin
      pixel_x <= '0;
      pixel_y <= '0;
      card_type <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        hit_d[i] <= 1'b0;
        val_d[i] <= 1'b0;
      end
      pix_hit <= 1'b0;
      pix_rgb <= '0;
      pix_valid <= 1'b0;
    end else begin
      pixel_x <= hit ? offset[5:0] : '0;
      pixel_y <= hit ? py : '0;
      card_type <= hit ? cur_type : '0;
      hit_d[0] <= hit;
      val_d[0] <= valid;
      for (int i = 1; i <= MEM_LAT; i++) begin
        hit_d[i] <= hit_d[i-1];
        val_d[i] <= val_d[i-1];
      end
      pix_hit <= hit_d[MEM_LAT];
      pix_rgb <= hit_d[MEM_LAT] ? card_pixel : BG_COLOR;
      pix_valid <= val_d[MEM_LAT];
    end
endmodule

// File: doc/card_row_renderer.md
Name: card_row_renderer

Overview:
- Scan-side initiator for the card pixel memory: follows the VGA beam (h_cnt/v_cnt) across one horizontal row of hand cards.
- Issues pixel_x/pixel_y/card_type requests to the card pixel ROM lookup and receives card_pixel back.
- Re-aligns the returned pixel with delayed beam coordinates and outputs a colour plus a hit flag for the display mux.
- Sits between the VGA timing generator and the final RGB mux.

Parameters:
- MAX_CARDS, 16, number of card slots in the row.
- X0, 64, h_cnt of the left edge of slot 0.
- Y0, 400, v_cnt of the top edge of an unselected card.
- PITCH, 36, horizontal slot pitch in pixels; must be ≥ 32.
- RAISE, 8, upward offset of the selected card in pixels.
- MEM_LAT, 1, clock cycles from request to card_pixel valid.
- V_LATCH, 480, v_cnt of the line where hand inputs are shadowed.
- BG_COLOR, 12'h000, colour driven when no card is hit.

Ports:
- clk_25MHz  in  1  pixel clock; h_cnt advances by 1 per clock.
- rst_n  in  1  asynchronous, active-low reset.
- h_cnt  in  10  beam column.
- v_cnt  in  10  beam line.
- valid  in  1  active video.
- hand_cards  in  6*MAX_CARDS  slot i card type in bits [6i+5:6i].
- hand_count  in  5  number of occupied slots, 0..MAX_CARDS.
- sel_idx  in  5  selected slot; values ≥ hand_count mean no card is selected.
- card_pixel  in  12  RGB444 returned by the card pixel memory.
- pixel_x  out  6  request column within the card, 0..31.
- pixel_y  out  6  request row within the card, 0..45.
- card_type  out  6  request card type, 0..53.
- pix_hit  out  1  output pixel lies on a card.
- pix_rgb  out  12  output colour.
- pix_valid  out  1  delayed copy of valid.

Behaviour:
- Reset (async, rst_n=0): every output register = 0, pix_rgb = 0. Shadow count = 0, so nothing is drawn until the first latch. Pipeline and slot counters are cleared.
- Frame shadowing:
  - Latch condition: v_cnt==V_LATCH && h_cnt==0.
  - On latch, copy hand_cards, hand_count and sel_idx into shadow registers.
  - Changes to these inputs at any other time have no effect until the next latch.
- Slot tracking (sequential, no divider):
  - Effective (slot, offset) for the current h_cnt:
    - h_cnt==X0 gives (0,0).
    - Otherwise use the registered values.
  - Each clock the registers load effective+1. Offset wraps PITCH-1→0 and slot increments on the wrap.
  - Slot saturates at MAX_CARDS, meaning out of row.
  - The counters resync at X0 on every line, so h_cnt discontinuities recover on the next line.
- Vertical window:
  - top = Y0 - RAISE when slot == shadow sel_idx, else Y0.
  - Row hit: v_cnt ≥ top and v_cnt < top+46.
  - py = v_cnt - top, truncated to 6 bits.
- Hit (stage 0, combinational):
  - All of: valid, slot < shadow count, offset < 32, row hit, and shadow card type ≤ 53.
  - Card types 54..63 count as empty slots.
- Stage 1 (registered, 1 cycle after the beam sample):
  - pixel_x = offset[5:0], pixel_y = py, card_type = slot's shadow type.
  - When there is no hit, all three = 0.
  - hit, valid and the beam sample are pushed into a delay line.
- Stage 2 (registered, 1+MEM_LAT cycles after stage 1):
  - pix_hit = delayed hit.
  - pix_rgb = delayed hit ? card_pixel : BG_COLOR.
  - pix_valid = delayed valid.
- Total latency from beam sample to pix_* = 2+MEM_LAT cycles (3 by default). This is constant, with no bubbles or stalls.
- Boundaries:
  - hand_count=0: no hits anywhere.
  - hand_count > MAX_CARDS: clamped to MAX_CARDS at the latch.
  - Gap columns (offset 32..PITCH-1): no hit.
  - Selected slot: pixels in lines top..Y0-1 hit only for that slot. Its lines Y0+46-RAISE..Y0+45 are uncovered (no hit).
  - Latch cycle coinciding with a hit: impossible, because V_LATCH lies outside the card rows.

Decomposition:
- Shared package holds:
  - CARD_W=32, CARD_H=46.
  - CARD_TYPE_W=6, MAX_CARD_TYPE=53.
  - RGB444 width constant.
  - Layout defaults X0/Y0/PITCH.
- One sub-module is natural: card_slot_tracker, containing the offset/slot counters and the resync logic.
- The delay line is an inline shift register sized by MEM_LAT.

Test Plan (defaults; model the memory as card_pixel = {card_type, pixel_y} after MEM_LAT):
- Reset and no latch: sweep a full frame -> pix_hit=0, pix_rgb=12'h000 throughout; pixel_x/pixel_y/card_type=0.
- Latch hand_count=1, slot0=5, sel=31. Beam at h=64, v=400 -> next cycle pixel_x=0, pixel_y=0, card_type=5. Three cycles after the sample: pix_hit=1, pix_rgb=12'h140.
- Same frame, h=99 (offset 35) -> pix_hit=0. h=100 with count=2 -> slot1, pixel_x=0. h=131 -> pixel_x=31, hit. h=132 -> no hit.
- Latch count=2, sel=1:
  - v=392, h=100 -> hit, pixel_y=0.
  - v=392, h=64 -> no hit.
  - v=440, h=100 -> no hit.
  - v=445, h=64 -> hit, pixel_y=45.
- Change hand_cards at v=200 -> rows 400..445 of the current frame still show the old types; the new types appear after v=480.
- Slot card type 60 -> no hit in that slot. Deassert rst_n at h=80, v=410 -> outputs 0 in the same cycle (async); correct rendering returns from the next latched frame.
